// File: rtl/ecap5_dproc_pkg.sv
// ---------------------------------------------------------------------------
// ecap5_dproc_pkg
// Shared types for the processor pipeline.
//   pipe_ctrl_state_t : trap sequencer state of pipeline_ctrl
//   INFLIGHT_STAGES   : number of stages tracked behind decode (ex, ls, wb)
// ---------------------------------------------------------------------------
package ecap5_dproc_pkg;

    typedef enum logic [1:0] {
        PIPE_RUN      = 2'd0,
        PIPE_DRAIN    = 2'd1,
        PIPE_REDIRECT = 2'd2
    } pipe_ctrl_state_t;

    localparam int INFLIGHT_STAGES = 3;

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter. It stops at all-ones and never wraps. The clear
// input takes priority over inc.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (count -> 0)
//   inc    in   count this cycle
//   clear  in   synchronous clear; count is 0 on the next cycle
//   count  out  current count (WIDTH bits)
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (inc && (count_reg != '1)) begin
            count_next = count_reg + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Central pipeline sequencer. It merges the hazard requests into per-stage
// stall and bubble controls and runs the trap entry. On a trap it drains
// the in-flight instructions, then pulses a single fetch redirect. It also
// counts stalled cycles with a saturating counter.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   dec_stall_request_i    data hazard at decode
//   ex_discard_request_i   branch discard of the instruction entering execute
//   if_busy_i, ls_busy_i   fetch / load-store waiting on the bus
//   dec_valid_i            decode holds a valid instruction
//   trap_request_i         trap pending, held until trap_redirect_o
//   stall_count_clear_i    synchronous clear of stall_count_o
//   if/dec/ex/ls_stall_o   hold the corresponding stage
//   dec/ex_bubble_o        load a NOP into the decode/execute input register
//   trap_redirect_o        one-cycle redirect of fetch to the trap vector
//   drain_o                trap sequence in progress (DRAIN or REDIRECT)
//   stall_count_o          saturating stalled-cycle count
// ---------------------------------------------------------------------------
module pipeline_ctrl
    import ecap5_dproc_pkg::*;
#(
    parameter int STALL_CNT_WIDTH = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       dec_stall_request_i,
    input  logic                       ex_discard_request_i,
    input  logic                       if_busy_i,
    input  logic                       ls_busy_i,
    input  logic                       dec_valid_i,
    input  logic                       trap_request_i,
    input  logic                       stall_count_clear_i,
    output logic                       if_stall_o,
    output logic                       dec_stall_o,
    output logic                       ex_stall_o,
    output logic                       ls_stall_o,
    output logic                       dec_bubble_o,
    output logic                       ex_bubble_o,
    output logic                       trap_redirect_o,
    output logic                       drain_o,
    output logic [STALL_CNT_WIDTH-1:0] stall_count_o
);

    pipe_ctrl_state_t state_reg;
    pipe_ctrl_state_t state_next;

    // In-flight tracker: bit 0 = execute, bit 1 = load-store, bit 2 = writeback.
    logic [INFLIGHT_STAGES-1:0] v_reg;
    logic [INFLIGHT_STAGES-1:0] v_next;
    logic                       issue;
    logic                       stall_inc;

    always_comb begin
        state_next      = state_reg;
        if_stall_o      = 1'b0;
        dec_stall_o     = 1'b0;
        ex_stall_o      = 1'b0;
        ls_stall_o      = 1'b0;
        dec_bubble_o    = 1'b0;
        ex_bubble_o     = 1'b0;
        trap_redirect_o = 1'b0;

        case (state_reg)
            PIPE_RUN: begin
                if (trap_request_i) begin
                    // Stop new work entering; anything already past decode drains.
                    if_stall_o   = 1'b1;
                    dec_bubble_o = 1'b1;
                    ex_bubble_o  = 1'b1;
                    state_next   = PIPE_DRAIN;
                end else if (ls_busy_i) begin
                    // The whole pipe waits behind the bus. Nothing may be discarded.
                    if_stall_o  = 1'b1;
                    dec_stall_o = 1'b1;
                    ex_stall_o  = 1'b1;
                    ls_stall_o  = 1'b1;
                end else if (ex_discard_request_i) begin
                    dec_bubble_o = 1'b1;
                    ex_bubble_o  = 1'b1;
                end else if (dec_stall_request_i) begin
                    if_stall_o  = 1'b1;
                    dec_stall_o = 1'b1;
                    ex_bubble_o = 1'b1;
                end else if (if_busy_i) begin
                    dec_bubble_o = 1'b1;
                end
            end
            PIPE_DRAIN: begin
                // Branch and dec-stall requests are irrelevant: no new instruction issues.
                if_stall_o   = 1'b1;
                dec_bubble_o = 1'b1;
                ex_bubble_o  = 1'b1;
                if (ls_busy_i) begin
                    ex_stall_o = 1'b1;
                    ls_stall_o = 1'b1;
                end
                if ((v_reg == '0) && !ls_busy_i) begin
                    state_next = PIPE_REDIRECT;
                end
            end
            PIPE_REDIRECT: begin
                trap_redirect_o = 1'b1;
                dec_bubble_o    = 1'b1;
                ex_bubble_o     = 1'b1;
                state_next      = PIPE_RUN;
            end
            default: begin
                state_next = PIPE_RUN;
            end
        endcase
    end

    assign issue     = dec_valid_i & ~dec_stall_o & ~ex_bubble_o;
    assign v_next    = ls_busy_i ? v_reg : {v_reg[INFLIGHT_STAGES-2:0], issue};
    assign drain_o   = (state_reg != PIPE_RUN);
    assign stall_inc = if_stall_o | dec_stall_o | drain_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= PIPE_RUN;
            v_reg     <= '0;
        end else begin
            state_reg <= state_next;
            v_reg     <= v_next;
        end
    end

    sat_counter #(
        .WIDTH(STALL_CNT_WIDTH)
    ) u_stall_counter (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .inc   (stall_inc),
        .clear (stall_count_clear_i),
        .count (stall_count_o)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
// Self-checking bench for pipeline_ctrl with a 4-bit stall counter. A
// behavioural model tracks the trap phase, the ages of the in-flight
// instructions and the stall count. Every stepped cycle is compared against
// that model. Directed scenarios pin the model with literal expectations.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;

    localparam int W    = 4;
    localparam int CMAX = (1 << W) - 1;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         dec_stall_request_i;
    logic         ex_discard_request_i;
    logic         if_busy_i;
    logic         ls_busy_i;
    logic         dec_valid_i;
    logic         trap_request_i;
    logic         stall_count_clear_i;
    logic         if_stall_o;
    logic         dec_stall_o;
    logic         ex_stall_o;
    logic         ls_stall_o;
    logic         dec_bubble_o;
    logic         ex_bubble_o;
    logic         trap_redirect_o;
    logic         drain_o;
    logic [W-1:0] stall_count_o;

    always #5 clk_i = ~clk_i;

    pipeline_ctrl #(
        .STALL_CNT_WIDTH(W)
    ) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .dec_stall_request_i (dec_stall_request_i),
        .ex_discard_request_i(ex_discard_request_i),
        .if_busy_i           (if_busy_i),
        .ls_busy_i           (ls_busy_i),
        .dec_valid_i         (dec_valid_i),
        .trap_request_i      (trap_request_i),
        .stall_count_clear_i (stall_count_clear_i),
        .if_stall_o          (if_stall_o),
        .dec_stall_o         (dec_stall_o),
        .ex_stall_o          (ex_stall_o),
        .ls_stall_o          (ls_stall_o),
        .dec_bubble_o        (dec_bubble_o),
        .ex_bubble_o         (ex_bubble_o),
        .trap_redirect_o     (trap_redirect_o),
        .drain_o             (drain_o),
        .stall_count_o       (stall_count_o)
    );

    int checks = 0;
    int errors = 0;

    // Model: phase 0 = normal, 1 = waiting for pipe empty, 2 = redirect.
    typedef struct packed {
        bit ifs, decs, exs, lss, decb, exb, redir, drain;
    } exp_t;

    int m_mode;
    int m_age[$];   // ages of issued instructions: 0 = ex, 1 = ls, 2 = wb
    int m_cnt;
    bit last_redir;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e = '0;
        if (m_mode == 0) begin
            if (trap_request_i)            begin e.ifs = 1; e.decb = 1; e.exb = 1; end
            else if (ls_busy_i)            begin e.ifs = 1; e.decs = 1; e.exs = 1; e.lss = 1; end
            else if (ex_discard_request_i) begin e.decb = 1; e.exb = 1; end
            else if (dec_stall_request_i)  begin e.ifs = 1; e.decs = 1; e.exb = 1; end
            else if (if_busy_i)            begin e.decb = 1; end
        end else if (m_mode == 1) begin
            e.ifs = 1; e.decb = 1; e.exb = 1; e.drain = 1;
            if (ls_busy_i) begin e.exs = 1; e.lss = 1; end
        end else begin
            e.redir = 1; e.decb = 1; e.exb = 1; e.drain = 1;
        end
        return e;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_age.delete();
        m_cnt = 0;
        last_redir = 0;
    endtask

    task automatic model_advance(input exp_t e);
        bit issue;
        bit empty;
        int nmode;
        int nq[$];
        issue = dec_valid_i && !e.decs && !e.exb;
        empty = (m_age.size() == 0);
        nmode = m_mode;
        if (m_mode == 0 && trap_request_i) nmode = 1;
        else if (m_mode == 1 && empty && !ls_busy_i) nmode = 2;
        else if (m_mode == 2) nmode = 0;
        if (stall_count_clear_i) m_cnt = 0;
        else if (e.ifs || e.decs || m_mode != 0) m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        if (!ls_busy_i) begin
            foreach (m_age[i]) if (m_age[i] + 1 < 3) nq.push_back(m_age[i] + 1);
            if (issue) nq.push_back(0);
            m_age = nq;
        end
        m_mode = nmode;
        last_redir = e.redir;
    endtask

    // One clock cycle: compare at the falling edge, then advance the model after the rising edge.
    task automatic step();
        exp_t e;
        @(negedge clk_i);
        e = model_out();
        chk("if_stall", if_stall_o, e.ifs);
        chk("dec_stall", dec_stall_o, e.decs);
        chk("ex_stall", ex_stall_o, e.exs);
        chk("ls_stall", ls_stall_o, e.lss);
        chk("dec_bubble", dec_bubble_o, e.decb);
        chk("ex_bubble", ex_bubble_o, e.exb);
        chk("trap_redirect", trap_redirect_o, e.redir);
        chk("drain", drain_o, e.drain);
        chk("stall_count", stall_count_o, m_cnt);
        @(posedge clk_i);
        #1;
        model_advance(e);
    endtask

    task automatic clear_inputs();
        dec_stall_request_i  = 0;
        ex_discard_request_i = 0;
        if_busy_i            = 0;
        ls_busy_i            = 0;
        dec_valid_i          = 0;
        trap_request_i       = 0;
        stall_count_clear_i  = 0;
    endtask

    task automatic do_reset();
        rst_ni = 0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1;
    endtask

    // Build v = 011 (two back-to-back issues), raise a trap at cycle 0 and
    // check the drain/redirect timeline cycle by cycle.
    task automatic trap_seq(input string tag, input int busy_from, input int busy_to, input int redir_c);
        clear_inputs();
        repeat (3) step();
        dec_valid_i = 1;
        repeat (2) step();
        trap_request_i = 1;
        #1;
        chk({tag, "_c0_drain"}, drain_o, 0);
        chk({tag, "_c0_ifstall"}, if_stall_o, 1);
        step();
        for (int c = 1; c <= redir_c + 1; c++) begin
            ls_busy_i = (c >= busy_from && c <= busy_to);
            if (c == redir_c + 1) trap_request_i = 0;
            #1;
            chk($sformatf("%s_c%0d_drain", tag, c), drain_o, (c <= redir_c));
            chk($sformatf("%s_c%0d_redirect", tag, c), trap_redirect_o, (c == redir_c));
            chk($sformatf("%s_c%0d_ls_stall", tag, c), ls_stall_o, (c >= busy_from && c <= busy_to));
            step();
        end
        ls_busy_i = 0;
        $display("trap sequence %s: redirect expected at cycle %0d", tag, redir_c);
    endtask

    // A trap must stay requested for the whole drain.
    always @(posedge clk_i) begin
        if (rst_ni && m_mode == 1) begin
            assert (trap_request_i) else $error("trap_request_i dropped during drain");
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        do_reset();

        // Reset release with idle inputs.
        #1;
        chk("reset_if_stall", if_stall_o, 0);
        chk("reset_dec_bubble", dec_bubble_o, 0);
        chk("reset_ex_bubble", ex_bubble_o, 0);
        chk("reset_redirect", trap_redirect_o, 0);
        chk("reset_drain", drain_o, 0);
        chk("reset_count", stall_count_o, 0);
        step();
        $display("reset: outputs idle");

        // Bus-busy beats discard; discard takes effect once the bus frees.
        ls_busy_i = 1; ex_discard_request_i = 1;
        #1;
        chk("busy_disc_ex_stall", ex_stall_o, 1);
        chk("busy_disc_ls_stall", ls_stall_o, 1);
        chk("busy_disc_dec_bubble", dec_bubble_o, 0);
        chk("busy_disc_ex_bubble", ex_bubble_o, 0);
        step();
        ls_busy_i = 0;
        #1;
        chk("disc_dec_bubble", dec_bubble_o, 1);
        chk("disc_ex_bubble", ex_bubble_o, 1);
        chk("disc_if_stall", if_stall_o, 0);
        chk("disc_ls_stall", ls_stall_o, 0);
        step();
        $display("busy/discard priority exercised");

        // Decode data hazard.
        clear_inputs();
        dec_stall_request_i = 1; dec_valid_i = 1;
        #1;
        chk("dstall_if_stall", if_stall_o, 1);
        chk("dstall_dec_stall", dec_stall_o, 1);
        chk("dstall_ex_bubble", ex_bubble_o, 1);
        step();
        $display("decode stall exercised");

        trap_seq("trap_plain", 99, 0, 4);
        trap_seq("trap_busy", 1, 2, 6);

        // Counter saturation and clear priority.
        clear_inputs();
        stall_count_clear_i = 1;
        step();
        stall_count_clear_i = 0;
        dec_stall_request_i = 1;
        #1;
        chk("sat_start", stall_count_o, 0);
        repeat (20) step();
        chk("sat_after_20", stall_count_o, 15);
        stall_count_clear_i = 1;
        step();
        chk("sat_clear", stall_count_o, 0);
        stall_count_clear_i = 0;
        step();
        chk("sat_after_clear", stall_count_o, 1);
        $display("counter saturation exercised");

        // Reset during drain: asynchronous return, no redirect pulse.
        clear_inputs();
        trap_request_i = 1;
        step();
        step();
        #1;
        chk("mid_drain_before", drain_o, 1);
        rst_ni = 0;
        #1;
        chk("mid_drain_drain", drain_o, 0);
        chk("mid_drain_redirect", trap_redirect_o, 0);
        chk("mid_drain_count", stall_count_o, 0);
        repeat (3) begin
            @(posedge clk_i);
            #1;
            chk("in_reset_redirect", trap_redirect_o, 0);
            chk("in_reset_drain", drain_o, 0);
        end
        clear_inputs();
        model_reset();
        rst_ni = 1;
        step();
        $display("reset during drain exercised");

        // Randomized traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            if (trap_request_i && last_redir) begin
                trap_request_i = 0;
            end else if (!trap_request_i && m_mode == 0 && $urandom_range(0, 29) == 0) begin
                trap_request_i = 1;
                $display("random trap raised at iteration %0d", n);
            end
            ls_busy_i            = ($urandom_range(0, 3) == 0);
            ex_discard_request_i = ($urandom_range(0, 5) == 0);
            dec_stall_request_i  = ($urandom_range(0, 4) == 0);
            if_busy_i            = ($urandom_range(0, 4) == 0);
            dec_valid_i          = ($urandom_range(0, 3) != 0);
            stall_count_clear_i  = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
